// File: rtl/memory_access_unit.sv
// ---------------------------------------------------------------------------
// memory_access_unit
// Load/store unit for an RV32I core talking to a word-wide synchronous RAM.
// Loads take two LOAD cycles: the first presents the word address, the second
// extracts and extends the returned word into memoryOutput. Sub-word stores
// use read-modify-write. STORE_PRELOAD fetches the old word, and the following
// STORE merges rs2 into that word and writes it back. Word stores write
// directly. Misaligned or illegal accesses and protocol-order violations send
// the unit into a FAULT state, which it leaves only on reset.
//
// Ports
//   clock                 sole clock, rising edge
//   reset                 synchronous, active-low
//   memoryMode[1:0]       NOP=00 LOAD=01 STORE_PRELOAD=10 STORE=11
//   funct3[2:0]           RV32I load/store width and sign code
//   address[31:0]         byte address
//   rs2[31:0]             store data
//   memoryOutput[31:0]    extended load result (registered)
//   memoryUnalignedAccess misaligned or illegal funct3 (combinational | sticky)
//   sequenceError         protocol-order violation (combinational | sticky)
//   ramAddress[29:0]      word address = address[31:2]
//   ramReadData[31:0]     RAM read data, valid one cycle after ramAddress
//   ramWriteData[31:0]    word to write
//   ramWriteEnable        whole-word write strobe
// ---------------------------------------------------------------------------
module memory_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  memoryMode,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] rs2,
    output logic [31:0] memoryOutput,
    output logic        memoryUnalignedAccess,
    output logic        sequenceError,
    output logic [29:0] ramAddress,
    input  logic [31:0] ramReadData,
    output logic [31:0] ramWriteData,
    output logic        ramWriteEnable
);

    localparam logic [1:0] MODE_NOP     = 2'b00;
    localparam logic [1:0] MODE_LOAD    = 2'b01;
    localparam logic [1:0] MODE_PRELOAD = 2'b10;
    localparam logic [1:0] MODE_STORE   = 2'b11;

    typedef enum logic [1:0] {IDLE, LOADED, PRELOADED, FAULT} stateType;

    stateType    stateReg, stateNext;
    logic [31:0] loadWordReg;
    logic [31:0] preloadWordReg;
    logic [29:0] preloadAddressReg;
    logic        freshReg;          // RAM data for the captured word is on ramReadData this cycle
    logic [31:0] memoryOutputReg;
    logic        unalignedStickyReg;
    logic        sequenceStickyReg;

    logic        unalignedNow;
    logic        sequenceNow;
    logic        writeNow;
    logic        loadDone;
    logic [31:0] capturedWord;
    logic [31:0] mergedWord;
    logic [31:0] shiftedWord;
    logic [31:0] extractedWord;
    logic [31:0] writeWord;

    assign ramAddress = address[31:2];

    // Alignment and funct3 legality.
    always_comb begin
        logic misaligned;
        logic illegalCode;
        misaligned  = ((funct3[1:0] == 2'b01) && address[0]) ||
                      ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
        if (memoryMode == MODE_LOAD)
            illegalCode = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        else
            illegalCode = (funct3 >= 3'b011);
        unalignedNow = (memoryMode != MODE_NOP) && (misaligned || illegalCode);
    end

    // The first cycle after entering LOADED/PRELOADED sees the word straight
    // from the RAM; after that (NOP wait cycles) the held copy is used, since
    // ramAddress may no longer point at it.
    always_comb begin
        if (freshReg)
            capturedWord = ramReadData;
        else if (stateReg == LOADED)
            capturedWord = loadWordReg;
        else
            capturedWord = preloadWordReg;
    end

    // Load extraction and store merge.
    always_comb begin
        shiftedWord = capturedWord >> {address[1:0], 3'b000};
        case (funct3)
            3'b000:  extractedWord = {{24{shiftedWord[7]}}, shiftedWord[7:0]};
            3'b100:  extractedWord = {24'd0, shiftedWord[7:0]};
            3'b001:  extractedWord = {{16{shiftedWord[15]}}, shiftedWord[15:0]};
            3'b101:  extractedWord = {16'd0, shiftedWord[15:0]};
            default: extractedWord = capturedWord;
        endcase

        mergedWord = capturedWord;
        case (funct3[1:0])
            2'b00:   mergedWord[{address[1:0], 3'b000} +: 8] = rs2[7:0];
            2'b01:   mergedWord[{address[1], 4'b0000} +: 16] = rs2[15:0];
            default: mergedWord = rs2;
        endcase
    end

    // Next-state and write control.
    always_comb begin
        stateNext   = stateReg;
        sequenceNow = 1'b0;
        writeNow    = 1'b0;
        writeWord   = 32'd0;
        loadDone    = 1'b0;
        case (stateReg)
            IDLE: begin
                case (memoryMode)
                    MODE_LOAD:    stateNext = LOADED;
                    MODE_PRELOAD: stateNext = PRELOADED;
                    MODE_STORE: begin
                        if (funct3 == 3'b010) begin
                            writeNow  = 1'b1;
                            writeWord = rs2;
                        end else if (funct3[2:1] == 2'b00) begin
                            sequenceNow = 1'b1;  // sub-word store without preload
                        end
                    end
                    default: ;
                endcase
            end
            LOADED: begin
                case (memoryMode)
                    MODE_LOAD: begin
                        loadDone  = 1'b1;
                        stateNext = IDLE;
                    end
                    MODE_PRELOAD, MODE_STORE: sequenceNow = 1'b1;
                    default: ;
                endcase
            end
            PRELOADED: begin
                case (memoryMode)
                    MODE_LOAD, MODE_PRELOAD: sequenceNow = 1'b1;
                    MODE_STORE: begin
                        if (address[31:2] != preloadAddressReg) begin
                            sequenceNow = 1'b1;
                        end else begin
                            writeNow  = 1'b1;
                            writeWord = mergedWord;
                            stateNext = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;  // FAULT holds
        endcase

        if (unalignedNow || sequenceNow) begin
            stateNext = FAULT;
            writeNow  = 1'b0;
            loadDone  = 1'b0;
        end
    end

    // Reset has priority over any access, including the combinational strobe.
    assign ramWriteEnable        = reset && writeNow;
    assign ramWriteData          = ramWriteEnable ? writeWord : 32'd0;
    assign memoryUnalignedAccess = reset && (unalignedNow || unalignedStickyReg);
    assign sequenceError         = reset && (sequenceNow || sequenceStickyReg);
    assign memoryOutput          = memoryOutputReg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg           <= IDLE;
            loadWordReg        <= 32'd0;
            preloadWordReg     <= 32'd0;
            preloadAddressReg  <= 30'd0;
            freshReg           <= 1'b0;
            memoryOutputReg    <= 32'd0;
            unalignedStickyReg <= 1'b0;
            sequenceStickyReg  <= 1'b0;
        end else begin
            stateReg           <= stateNext;
            unalignedStickyReg <= unalignedStickyReg | unalignedNow;
            sequenceStickyReg  <= sequenceStickyReg | sequenceNow;
            freshReg           <= (stateReg == IDLE) &&
                                  ((stateNext == LOADED) || (stateNext == PRELOADED));
            if (freshReg) begin
                if (stateReg == LOADED)
                    loadWordReg <= ramReadData;
                else
                    preloadWordReg <= ramReadData;
            end
            if ((stateReg == IDLE) && (stateNext == PRELOADED))
                preloadAddressReg <= address[31:2];
            if (loadDone)
                memoryOutputReg <= extractedWord;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] LD  = 2'b01;
    localparam logic [1:0] PRE = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  memoryMode;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] rs2;
    logic [31:0] memoryOutput;
    logic        memoryUnalignedAccess;
    logic        sequenceError;
    logic [29:0] ramAddress;
    logic [31:0] ramReadData;
    logic [31:0] ramWriteData;
    logic        ramWriteEnable;

    int checks = 0;
    int errors = 0;
    int writeCount = 0;

    logic [31:0] ram [256];
    logic [31:0] refMem [256];
    logic        pokeEn = 1'b0;
    logic [7:0]  pokeIdx = 8'd0;
    logic [31:0] pokeVal = 32'd0;

    always #5 clock = ~clock;

    memory_access_unit dut (
        .clock                 (clock),
        .reset                 (reset),
        .memoryMode            (memoryMode),
        .funct3                (funct3),
        .address               (address),
        .rs2                   (rs2),
        .memoryOutput          (memoryOutput),
        .memoryUnalignedAccess (memoryUnalignedAccess),
        .sequenceError         (sequenceError),
        .ramAddress            (ramAddress),
        .ramReadData           (ramReadData),
        .ramWriteData          (ramWriteData),
        .ramWriteEnable        (ramWriteEnable)
    );

    // Synchronous RAM with a bench-side fill port.
    always @(posedge clock) begin
        ramReadData <= ram[ramAddress[7:0]];
        if (pokeEn)
            ram[pokeIdx] <= pokeVal;
        else if (ramWriteEnable)
            ram[ramAddress[7:0]] <= ramWriteData;
        if (ramWriteEnable)
            writeCount <= writeCount + 1;
    end

    // Reference behaviour of RV32I loads and sub-word stores on a word.
    function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [2:0] f,
                                            input int lane);
        logic [31:0] b, h;
        b = (w >> (8 * lane)) & 32'hFF;
        h = (w >> (8 * lane)) & 32'hFFFF;
        case (f)
            3'b000:  return (b > 127) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h > 32767) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] old, input logic [2:0] f,
                                             input int lane, input logic [31:0] d);
        case (f)
            3'b000:  return (old & ~(32'hFF << (8 * lane))) | ((d & 32'hFF) << (8 * lane));
            3'b001:  return (old & ~(32'hFFFF << (8 * lane))) | ((d & 32'hFFFF) << (8 * lane));
            default: return d;
        endcase
    endfunction

    // Drive inputs just after a rising edge, then wait to mid-cycle for sampling.
    task automatic drive(input logic [1:0] m, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        memoryMode = m;
        funct3     = f;
        address    = a;
        rs2        = d;
        @(negedge clock);
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        memoryMode = NOP;
        pokeEn     = 1'b1;
        pokeIdx    = idx;
        pokeVal    = val;
        advance();
        pokeEn     = 1'b0;
    endtask

    task automatic doReset();
        memoryMode = NOP;
        funct3     = 3'd0;
        address    = 32'd0;
        rs2        = 32'd0;
        reset      = 1'b0;
        advance();
        reset      = 1'b1;
    endtask

    task automatic test_reset();
        int wc;
        wc = writeCount;
        reset = 1'b0;
        drive(ST, 3'b010, 32'h40, 32'h1234_5678);
        checks++;
        if (ramWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority_we: got %b want 0", ramWriteEnable);
        end
        advance();
        reset = 1'b1;
        drive(NOP, 3'd0, 32'd0, 32'd0);
        checks++;
        if ({memoryOutput, memoryUnalignedAccess, sequenceError, ramWriteEnable, ramWriteData,
             ramAddress} !== {32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 30'd0}) begin
            errors++;
            $display("FAIL reset_state: out=%h ua=%b se=%b we=%b wd=%h ra=%h want all 0",
                     memoryOutput, memoryUnalignedAccess, sequenceError, ramWriteEnable,
                     ramWriteData, ramAddress);
        end
        checks++;
        if (writeCount !== wc) begin
            errors++;
            $display("FAIL reset_no_write: writes=%0d want %0d", writeCount - wc, 0);
        end
        advance();
        $display("test_reset done");
    endtask

    task automatic test_lb();
        int wc;
        doReset();
        poke(8'h40, 32'h8033_F1A2);
        wc = writeCount;
        drive(LD, 3'b000, 32'h101, 32'd0);
        advance();
        drive(LD, 3'b000, 32'h101, 32'd0);
        advance();
        drive(NOP, 3'd0, 32'd0, 32'd0);
        checks++;
        if (memoryOutput !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL lb_result: got %h want FFFFFFF1", memoryOutput);
        end
        checks++;
        if (writeCount !== wc || sequenceError !== 1'b0 || memoryUnalignedAccess !== 1'b0) begin
            errors++;
            $display("FAIL lb_side_effects: writes=%0d se=%b ua=%b want 0 0 0",
                     writeCount - wc, sequenceError, memoryUnalignedAccess);
        end
        advance();
        $display("lb addr=101 out=%h", memoryOutput);
    endtask

    task automatic test_sh();
        int wc;
        doReset();
        poke(8'h40, 32'h1122_3344);
        wc = writeCount;
        drive(PRE, 3'b001, 32'h102, 32'hAAAA_BEEF);
        checks++;
        if (ramWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL sh_preload_we: got %b want 0", ramWriteEnable);
        end
        advance();
        drive(ST, 3'b001, 32'h102, 32'hAAAA_BEEF);
        checks++;
        if ({ramWriteEnable, ramAddress, ramWriteData} !== {1'b1, 30'h40, 32'hBEEF_3344}) begin
            errors++;
            $display("FAIL sh_write: we=%b ra=%h wd=%h want 1 40 BEEF3344",
                     ramWriteEnable, ramAddress, ramWriteData);
        end
        advance();
        drive(NOP, 3'd0, 32'd0, 32'd0);
        checks++;
        if (writeCount - wc !== 1 || ramWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL sh_write_count: writes=%0d we=%b want 1 0", writeCount - wc,
                     ramWriteEnable);
        end
        advance();
        $display("sh addr=102 ram[40]=%h", ram[8'h40]);
    endtask

    task automatic test_sw();
        int wc;
        doReset();
        wc = writeCount;
        drive(ST, 3'b010, 32'h200, 32'hDEAD_BEEF);
        checks++;
        if ({ramWriteEnable, ramAddress, ramWriteData, memoryUnalignedAccess, sequenceError}
            !== {1'b1, 30'h80, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sw_write: we=%b ra=%h wd=%h ua=%b se=%b want 1 80 DEADBEEF 0 0",
                     ramWriteEnable, ramAddress, ramWriteData, memoryUnalignedAccess,
                     sequenceError);
        end
        advance();
        drive(NOP, 3'd0, 32'd0, 32'd0);
        checks++;
        if (writeCount - wc !== 1 || ramWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL sw_one_cycle: writes=%0d we=%b want 1 0", writeCount - wc,
                     ramWriteEnable);
        end
        advance();
        $display("sw addr=200 data=DEADBEEF");
    endtask

    task automatic test_unaligned();
        int wc;
        logic [31:0] held;
        doReset();
        poke(8'h10, 32'h0000_0085);
        drive(LD, 3'b100, 32'h40, 32'd0);
        advance();
        drive(LD, 3'b100, 32'h40, 32'd0);
        advance();
        held = 32'h85;
        wc = writeCount;
        drive(LD, 3'b010, 32'h102, 32'd0);
        checks++;
        if (memoryUnalignedAccess !== 1'b1) begin
            errors++;
            $display("FAIL lw_unaligned_now: got %b want 1", memoryUnalignedAccess);
        end
        advance();
        drive(NOP, 3'd0, 32'd0, 32'd0);
        checks++;
        if (memoryUnalignedAccess !== 1'b1) begin
            errors++;
            $display("FAIL lw_unaligned_sticky: got %b want 1", memoryUnalignedAccess);
        end
        advance();
        drive(ST, 3'b010, 32'h80, 32'h5555_AAAA);
        checks++;
        if (ramWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL fault_store_we: got %b want 0", ramWriteEnable);
        end
        advance();
        drive(LD, 3'b010, 32'h40, 32'd0);
        advance();
        drive(LD, 3'b010, 32'h40, 32'd0);
        advance();
        drive(NOP, 3'd0, 32'd0, 32'd0);
        checks++;
        if (writeCount !== wc || memoryOutput !== held) begin
            errors++;
            $display("FAIL fault_hold: writes=%0d out=%h want 0 %h", writeCount - wc,
                     memoryOutput, held);
        end
        advance();
        // Other illegal forms, each from a clean state.
        doReset();
        drive(LD, 3'b001, 32'h3, 32'd0);
        checks++;
        if (memoryUnalignedAccess !== 1'b1) begin
            errors++;
            $display("FAIL lh_odd: got %b want 1", memoryUnalignedAccess);
        end
        advance();
        doReset();
        drive(ST, 3'b011, 32'h40, 32'd0);
        checks++;
        if ({memoryUnalignedAccess, ramWriteEnable} !== 2'b10) begin
            errors++;
            $display("FAIL store_f3_011: ua=%b we=%b want 1 0", memoryUnalignedAccess,
                     ramWriteEnable);
        end
        advance();
        doReset();
        drive(LD, 3'b110, 32'h40, 32'd0);
        checks++;
        if (memoryUnalignedAccess !== 1'b1) begin
            errors++;
            $display("FAIL load_f3_110: got %b want 1", memoryUnalignedAccess);
        end
        advance();
        $display("unaligned tests done");
    endtask

    task automatic test_sequence();
        int wc;
        doReset();
        wc = writeCount;
        drive(ST, 3'b000, 32'h41, 32'h77);
        checks++;
        if ({sequenceError, ramWriteEnable} !== 2'b10) begin
            errors++;
            $display("FAIL sb_idle: se=%b we=%b want 1 0", sequenceError, ramWriteEnable);
        end
        advance();
        doReset();
        drive(NOP, 3'd0, 32'd0, 32'd0);
        checks++;
        if ({memoryOutput, memoryUnalignedAccess, sequenceError, ramWriteEnable, ramWriteData}
            !== 67'd0 || writeCount !== wc) begin
            errors++;
            $display("FAIL seq_reset_clear: out=%h ua=%b se=%b we=%b writes=%0d want 0",
                     memoryOutput, memoryUnalignedAccess, sequenceError, ramWriteEnable,
                     writeCount - wc);
        end
        advance();
        // Preload at one word, store to another.
        drive(PRE, 3'b000, 32'h44, 32'd0);
        advance();
        drive(ST, 3'b000, 32'h48, 32'd0);
        checks++;
        if ({sequenceError, ramWriteEnable} !== 2'b10) begin
            errors++;
            $display("FAIL store_addr_mismatch: se=%b we=%b want 1 0", sequenceError,
                     ramWriteEnable);
        end
        advance();
        doReset();
        drive(LD, 3'b010, 32'h44, 32'd0);
        advance();
        drive(PRE, 3'b010, 32'h44, 32'd0);
        checks++;
        if (sequenceError !== 1'b1) begin
            errors++;
            $display("FAIL preload_in_loaded: got %b want 1", sequenceError);
        end
        advance();
        doReset();
        drive(PRE, 3'b001, 32'h44, 32'd0);
        advance();
        drive(LD, 3'b001, 32'h44, 32'd0);
        checks++;
        if (sequenceError !== 1'b1) begin
            errors++;
            $display("FAIL load_in_preloaded: got %b want 1", sequenceError);
        end
        advance();
        // Reset between preload and store abandons the store.
        doReset();
        wc = writeCount;
        drive(PRE, 3'b000, 32'h45, 32'd0);
        advance();
        doReset();
        drive(ST, 3'b000, 32'h45, 32'h99);
        checks++;
        if ({sequenceError, ramWriteEnable} !== 2'b10) begin
            errors++;
            $display("FAIL abandon_store: se=%b we=%b want 1 0", sequenceError, ramWriteEnable);
        end
        advance();
        drive(NOP, 3'd0, 32'd0, 32'd0);
        checks++;
        if (writeCount !== wc || sequenceError !== 1'b1) begin
            errors++;
            $display("FAIL abandon_after: writes=%0d se=%b want 0 1", writeCount - wc,
                     sequenceError);
        end
        advance();
        $display("sequence tests done");
    endtask

    task automatic test_random();
        logic [31:0] val, expect_v, data;
        logic [2:0]  f;
        int word, lane, kind, nops;
        logic [2:0] loadCodes [5];
        loadCodes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        doReset();
        for (int i = 0; i < 256; i++) begin
            val = $urandom;
            refMem[i] = val;
            poke(i[7:0], val);
        end
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 2);
            word = $urandom_range(0, 255);
            nops = $urandom_range(0, 2);
            data = $urandom;
            if (kind == 0) begin
                f = loadCodes[$urandom_range(0, 4)];
                lane = (f[1:0] == 2'b00) ? $urandom_range(0, 3) :
                       (f[1:0] == 2'b01) ? 2 * $urandom_range(0, 1) : 0;
                drive(LD, f, word * 4 + lane, 32'd0);
                advance();
                for (int k = 0; k < nops; k++) begin
                    drive(NOP, 3'($urandom), $urandom, $urandom);
                    checks++;
                    if ({ramWriteEnable, memoryUnalignedAccess, sequenceError} !== 3'b000) begin
                        errors++;
                        $display("FAIL rnd_load_wait: we=%b ua=%b se=%b want 0 0 0",
                                 ramWriteEnable, memoryUnalignedAccess, sequenceError);
                    end
                    advance();
                end
                drive(LD, f, word * 4 + lane, 32'd0);
                advance();
                expect_v = refLoad(refMem[word], f, lane);
                drive(NOP, 3'd0, 32'd0, 32'd0);
                checks++;
                if (memoryOutput !== expect_v) begin
                    errors++;
                    $display("FAIL rnd_load: f3=%b addr=%h got %h want %h", f, word * 4 + lane,
                             memoryOutput, expect_v);
                end
                advance();
                $display("load f3=%b addr=%h out=%h", f, word * 4 + lane, memoryOutput);
            end else begin
                if (kind == 1) begin
                    f = 3'($urandom_range(0, 1));
                    lane = (f == 3'b000) ? $urandom_range(0, 3) : 2 * $urandom_range(0, 1);
                    drive(PRE, f, word * 4 + lane, data);
                    advance();
                    for (int k = 0; k < nops; k++) begin
                        drive(NOP, 3'($urandom), $urandom, $urandom);
                        advance();
                    end
                end else begin
                    f = 3'b010;
                    lane = 0;
                end
                expect_v = refStore(refMem[word], f, lane, data);
                drive(ST, f, word * 4 + lane, data);
                checks++;
                if ({ramWriteEnable, ramAddress, ramWriteData} !== {1'b1, 30'(word), expect_v}) begin
                    errors++;
                    $display("FAIL rnd_store: f3=%b addr=%h we=%b ra=%h wd=%h want 1 %h %h", f,
                             word * 4 + lane, ramWriteEnable, ramAddress, ramWriteData,
                             word, expect_v);
                end
                refMem[word] = expect_v;
                advance();
                $display("store f3=%b addr=%h data=%h", f, word * 4 + lane, expect_v);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        memoryMode = NOP;
        funct3     = 3'd0;
        address    = 32'd0;
        rs2        = 32'd0;
        advance();
        test_reset();
        test_lb();
        test_sh();
        test_sw();
        test_unaligned();
        test_sequence();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock and reset are named as the codebase names them.
REQ-002 Port `clock`: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 Port `reset`: input, 1 bit, synchronous, active-low; sampled on the rising edge of `clock`.
REQ-004 Port `memoryMode`: input, 2 bits. Encoding: NOP=00, LOAD=01, STORE_PRELOAD=10, STORE=11. Driven by core control logic, stable for a whole cycle.
REQ-005 Port `funct3`: input, 3 bits; RV32I load/store width and sign code of the current instruction.
REQ-006 Port `address`: input, 32 bits; byte address (rs1+imm), computed upstream.
REQ-007 Port `rs2`: input, 32 bits; store data.
REQ-008 Port `memoryOutput`: output, 32 bits; extended load result for rd.
REQ-009 Port `memoryUnalignedAccess`: output, 1 bit; misaligned or illegal-funct3 access flag.
REQ-010 Port `sequenceError`: output, 1 bit; protocol-order violation flag.
REQ-011 Port `ramAddress`: output, 30 bits; word address, equal to `address[31:2]`, combinational.
REQ-012 Port `ramReadData`: input, 32 bits; synchronous RAM read data, valid one cycle after `ramAddress`.
REQ-013 Port `ramWriteData`: output, 32 bits; full word to write.
REQ-014 Port `ramWriteEnable`: output, 1 bit; whole-word write strobe.

Function
REQ-015 The FSM SHALL have states IDLE, LOADED, PRELOADED and FAULT.
REQ-016 LOAD in IDLE: go to LOADED; capture `ramReadData` on the following edge into the load word register.
REQ-017 LOAD in LOADED (the second load cycle): drive `memoryOutput` from the captured word, then return to IDLE.
REQ-018 Load extraction: byte lane = `address[1:0]`, halfword lane = `address[1]`.
- lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word.
- Latency: two cycles from the first LOAD to a valid `memoryOutput`.
REQ-019 STORE_PRELOAD in IDLE: go to PRELOADED; capture the old word and latch `address[31:2]`.
REQ-020 STORE in PRELOADED (sb or sh): merge the selected `rs2` byte or halfword into the preloaded word at the lane given by `address[1:0]`.
- Drive the merged word on `ramWriteData`.
- Assert `ramWriteEnable` for exactly that cycle.
- Return to IDLE.
REQ-021 STORE in IDLE with funct3=sw: write `rs2` directly with `ramWriteEnable` for one cycle; no preload is needed.
REQ-022 `ramWriteEnable` SHALL be 0 in every cycle not described in REQ-020 or REQ-021.
REQ-023 `memoryUnalignedAccess` SHALL be combinational: asserted whenever `memoryMode`≠NOP and any of the following holds:
- halfword access with `address[0]`=1;
- word access with `address[1:0]`≠00;
- load funct3 in {011,110,111};
- store funct3 ≥011.
REQ-024 Any access that raises `memoryUnalignedAccess` SHALL suppress `ramWriteEnable` and send the FSM to FAULT.
REQ-025 `sequenceError` SHALL assert combinationally, and the FSM go to FAULT, in each of these cases:
- STORE with sb or sh while in IDLE;
- STORE whose word address differs from the latched preload address;
- STORE_PRELOAD or STORE while in LOADED;
- LOAD or STORE_PRELOAD while in PRELOADED.
REQ-026 FAULT is sticky until reset.
- Both flags stay asserted.
- `ramWriteEnable` stays 0.
- `memoryOutput` holds its value.
REQ-027 NOP in LOADED or PRELOADED SHALL hold the state and captured data; NOP in IDLE has no effect.
REQ-028 A simultaneous reset and access SHALL give priority to reset.

Reset
REQ-029 When `reset` is 0 at a rising edge, the block SHALL load these values:
- state IDLE;
- `memoryOutput` 0;
- load and preload registers 0;
- both sticky flags 0;
- `ramWriteEnable` 0.
REQ-030 A reset between STORE_PRELOAD and STORE SHALL abandon the store; no write occurs.

Verification
REQ-031 lb: RAM[0x40]=0x8033_F1A2, address=0x101, funct3=000. LOAD held two cycles → `memoryOutput`=0xFFFF_FFF1; `ramWriteEnable` never 1.
REQ-032 sh: RAM word 0x40 (byte 0x100)=0x1122_3344, rs2=0xAAAA_BEEF, address=0x102, STORE_PRELOAD then STORE → one write of 0xBEEF_3344 to ramAddress 0x40.
REQ-033 sw: address=0x200, rs2=0xDEAD_BEEF, single STORE → `ramWriteData`=0xDEAD_BEEF with `ramWriteEnable` for one cycle; no flags.
REQ-034 lw at address=0x102 → `memoryUnalignedAccess`=1 in the same cycle, still 1 afterwards, and no write after further STOREs.
REQ-035 sb STORE issued in IDLE → `sequenceError`=1 and no write. After `reset`=0 for one edge, all outputs are 0 and the state is IDLE.
REQ-036 STORE_PRELOAD, then `reset`=0, then STORE with sb → no write; `sequenceError`=1.
